// File: rtl/tag_cmp_arb_if.sv
// Bundle of requester-side and memory-side signals for the tag compare arbiter.
// slave is the arbiter's view; master is the environment's (requesters + SRAM wrappers).
interface tag_cmp_arb_if #(
  parameter int unsigned NR_PORTS   = 3,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 44,
  parameter int unsigned SET_ASSOC  = 8,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned BE_WIDTH   = 16,
  parameter int unsigned ERR_CNT_W  = 8
);
  localparam int unsigned IdW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } l_data_t;

  typedef logic [BE_WIDTH-1:0] l_be_t;

  logic [NR_PORTS-1:0][SET_ASSOC-1:0]  req_i;
  logic [NR_PORTS-1:0]                 lock_i;
  logic [NR_PORTS-1:0]                 gnt_o;
  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
  l_data_t [NR_PORTS-1:0]              wdata_i;
  logic [NR_PORTS-1:0]                 we_i;
  l_be_t [NR_PORTS-1:0]                be_i;
  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  tag_i;
  logic [SET_ASSOC-1:0]                req_o;
  logic [ADDR_WIDTH-1:0]               addr_o;
  l_data_t                             wdata_o;
  logic                                we_o;
  l_be_t                               be_o;
  l_data_t [SET_ASSOC-1:0]             rdata_i;
  l_data_t [SET_ASSOC-1:0]             rdata_o;
  logic [SET_ASSOC-1:0]                hit_way_o;
  logic                                cmp_valid_o;
  logic [IdW-1:0]                      cmp_id_o;
  logic                                multihit_o;
  logic [ERR_CNT_W-1:0]                multihit_cnt_o;

  modport slave (
    input  req_i, lock_i, addr_i, wdata_i, we_i, be_i, tag_i, rdata_i,
    output gnt_o, req_o, addr_o, wdata_o, we_o, be_o, rdata_o,
    output hit_way_o, cmp_valid_o, cmp_id_o, multihit_o, multihit_cnt_o
  );

  modport master (
    output req_i, lock_i, addr_i, wdata_i, we_i, be_i, tag_i, rdata_i,
    input  gnt_o, req_o, addr_o, wdata_o, we_o, be_o, rdata_o,
    input  hit_way_o, cmp_valid_o, cmp_id_o, multihit_o, multihit_cnt_o
  );
endinterface

// File: rtl/tag_cmp_arb.sv
// Arbitrates NR_PORTS requesters onto shared tag/data SRAMs and performs the
// following-cycle tag compare, reporting hitting way, owning port and multi-hits.
module tag_cmp_arb #(
  parameter int unsigned NR_PORTS  = 3,
  parameter int unsigned SET_ASSOC = 8,
  parameter bit          RR_ARB    = 1'b1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          clr_i,
  tag_cmp_arb_if.slave bus
);
  localparam int unsigned IdW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic [NR_PORTS-1:0]  port_req;
  logic [NR_PORTS-1:0]  gnt;
  logic                 any_req;
  logic                 locked_win;
  logic [IdW-1:0]       win_id;
  int unsigned          rr_idx;

  logic [IdW-1:0]       rr_ptr_q, lock_id_q, id_q;
  logic                 lock_q, valid_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic [SET_ASSOC-1:0] hit;
  logic                 multihit;

  always_comb begin
    port_req   = '0;
    gnt        = '0;
    win_id     = '0;
    locked_win = 1'b0;
    rr_idx     = 0;
    for (int i = 0; i < NR_PORTS; i++) port_req[i] = |bus.req_i[i];
    any_req = |port_req;
    if (lock_q && port_req[lock_id_q]) begin
      locked_win = 1'b1;
      win_id     = lock_id_q;
    end else if (!RR_ARB) begin
      // Descending scan so the lowest requesting index is the last write.
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
        if (port_req[i]) win_id = IdW'(i);
      end
    end else begin
      for (int k = NR_PORTS; k >= 1; k--) begin
        rr_idx = (int'(rr_ptr_q) + k) % NR_PORTS;
        if (port_req[rr_idx]) win_id = IdW'(rr_idx);
      end
    end
    if (any_req) gnt[win_id] = 1'b1;
  end

  always_comb begin
    bus.gnt_o   = gnt;
    bus.req_o   = any_req ? bus.req_i[win_id]   : '0;
    bus.addr_o  = any_req ? bus.addr_i[win_id]  : '0;
    bus.wdata_o = any_req ? bus.wdata_i[win_id] : '0;
    bus.we_o    = any_req ? bus.we_i[win_id]    : 1'b0;
    bus.be_o    = any_req ? bus.be_i[win_id]    : '0;
    bus.rdata_o = bus.rdata_i;
  end

  always_comb begin
    hit = '0;
    for (int j = 0; j < SET_ASSOC; j++) begin
      hit[j] = valid_q & bus.rdata_i[j].valid & (bus.rdata_i[j].tag == bus.tag_i[id_q]);
    end
    multihit            = valid_q & ($countones(hit) > 1);
    bus.hit_way_o       = hit;
    bus.cmp_valid_o     = valid_q;
    bus.cmp_id_o        = id_q;
    bus.multihit_o      = multihit;
    bus.multihit_cnt_o  = cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      id_q      <= '0;
      rr_ptr_q  <= IdW'(NR_PORTS - 1);
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else if (clr_i) begin
      valid_q   <= 1'b0;
      id_q      <= '0;
      rr_ptr_q  <= IdW'(NR_PORTS - 1);
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q <= any_req;
      if (any_req) begin
        id_q      <= win_id;
        lock_q    <= bus.lock_i[win_id];
        lock_id_q <= win_id;
        // Pointer stays frozen while a locked grant is being honoured.
        if (!locked_win) rr_ptr_q <= win_id;
      end else begin
        lock_q <= 1'b0;
      end
      if (multihit && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_tag_cmp_arb.sv
// Bench for tag_cmp_arb: a round-robin and a fixed-priority instance share stimulus;
// a reference model predicts grants and a queue carries expected compares one cycle ahead.
module tb_tag_cmp_arb;
  localparam int unsigned NP = 3;
  localparam int unsigned SA = 8;

  logic clk, rst, clr;

  tag_cmp_arb_if #(.NR_PORTS(NP), .SET_ASSOC(SA)) bus ();
  tag_cmp_arb_if #(.NR_PORTS(NP), .SET_ASSOC(SA)) bus_fp ();

  assign bus_fp.req_i   = bus.req_i;
  assign bus_fp.lock_i  = bus.lock_i;
  assign bus_fp.addr_i  = bus.addr_i;
  assign bus_fp.wdata_i = bus.wdata_i;
  assign bus_fp.we_i    = bus.we_i;
  assign bus_fp.be_i    = bus.be_i;
  assign bus_fp.tag_i   = bus.tag_i;
  assign bus_fp.rdata_i = bus.rdata_i;

  tag_cmp_arb #(.NR_PORTS(NP), .SET_ASSOC(SA), .RR_ARB(1'b1), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .bus(bus)
  );

  tag_cmp_arb #(.NR_PORTS(NP), .SET_ASSOC(SA), .RR_ARB(1'b0), .ERR_CNT_W(8)) dut_fp (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .bus(bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int id;
  } pend_t;

  pend_t pend[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    m_ptr[2];
  int    m_lid[2];
  bit    m_lock[2];
  int    cnt_m;

  logic [NP-1:0]  gnt_seen, fp_gnt_seen;
  logic [63:0]    fp_addr_seen;
  logic           cv_seen, mh_seen, fp_cv_seen;
  logic [1:0]     id_seen, fp_id_seen;
  logic [SA-1:0]  hit_seen;
  logic [7:0]     cnt_seen;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int arb(input bit rr, input int ptr, input bit lk, input int lid,
                             input bit [NP-1:0] preq, output bit locked);
    locked = 1'b0;
    if (preq == '0) return -1;
    if (lk && preq[lid]) begin
      locked = 1'b1;
      return lid;
    end
    if (!rr) begin
      for (int i = 0; i < NP; i++) if (preq[i]) return i;
    end
    for (int k = 1; k <= NP; k++) if (preq[(ptr + k) % NP]) return (ptr + k) % NP;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]  = NP - 1;
      m_lid[d]  = 0;
      m_lock[d] = 1'b0;
    end
  endtask

  // One clock: called just after a rising edge with inputs already driven.
  task automatic step();
    int            w[2];
    bit            lw[2];
    bit [NP-1:0]   preq;
    pend_t         p;
    logic [SA-1:0] eh;
    logic [63:0]   eaddr;
    bit            emh;
    for (int i = 0; i < NP; i++) preq[i] = |bus.req_i[i];
    if (rst) begin
      model_reset();
      pend.delete();
      pend.push_back('{v: 1'b0, id: 0});
      cnt_m = 0;
    end
    for (int d = 0; d < 2; d++) w[d] = arb(d == 0, m_ptr[d], m_lock[d], m_lid[d], preq, lw[d]);
    if (pend.size() == 0) begin
      check_eq("pend_empty", 64'd0, 64'd1);
      p = '{v: 1'b0, id: 0};
    end else begin
      p = pend.pop_front();
    end
    eh = '0;
    for (int j = 0; j < SA; j++) begin
      if (p.v && bus.rdata_i[j].valid && (bus.rdata_i[j].tag == bus.tag_i[p.id])) eh[j] = 1'b1;
    end
    emh   = p.v && ($countones(eh) > 1);
    eaddr = (w[0] >= 0) ? bus.addr_i[w[0]] : 64'd0;
    #4;
    gnt_seen     = bus.gnt_o;
    fp_gnt_seen  = bus_fp.gnt_o;
    fp_addr_seen = bus_fp.addr_o;
    cv_seen      = bus.cmp_valid_o;
    id_seen      = bus.cmp_id_o;
    fp_cv_seen   = bus_fp.cmp_valid_o;
    fp_id_seen   = bus_fp.cmp_id_o;
    hit_seen     = bus.hit_way_o;
    mh_seen      = bus.multihit_o;
    cnt_seen     = bus.multihit_cnt_o;
    check_eq("gnt_rr", gnt_seen, (w[0] >= 0) ? (64'd1 << w[0]) : 64'd0);
    check_eq("gnt_fp", fp_gnt_seen, (w[1] >= 0) ? (64'd1 << w[1]) : 64'd0);
    check_eq("addr_o", bus.addr_o, eaddr);
    check_eq("cmp_valid", cv_seen, p.v);
    if (p.v) check_eq("cmp_id", id_seen, p.id);
    check_eq("hit_way", hit_seen, eh);
    check_eq("multihit", mh_seen, emh);
    check_eq("mh_cnt", cnt_seen, cnt_m);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || clr) begin
        m_ptr[d]  = NP - 1;
        m_lid[d]  = 0;
        m_lock[d] = 1'b0;
      end else if (w[d] >= 0) begin
        if (!lw[d]) m_ptr[d] = w[d];
        m_lock[d] = bus.lock_i[w[d]];
        m_lid[d]  = w[d];
      end else begin
        m_lock[d] = 1'b0;
      end
    end
    pend.push_back('{v: (w[0] >= 0) && !rst && !clr, id: (w[0] >= 0) ? w[0] : 0});
    if (rst || clr) cnt_m = 0;
    else if (emh && cnt_m < 255) cnt_m++;
    #1;
  endtask

  task automatic set_way(input int j, input bit v, input logic [43:0] t);
    bus.rdata_i[j].valid = v;
    bus.rdata_i[j].tag   = t;
    bus.rdata_i[j].data  = {4{32'(j)}};
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.req_i   = '0;
    bus.lock_i  = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
    bus.tag_i   = '0;
    bus.rdata_i = '0;
    for (int i = 0; i < NP; i++) bus.addr_i[i] = 64'h1000 * (i + 1);
    model_reset();
    cnt_m = 0;
    pend.push_back('{v: 1'b0, id: 0});
    @(posedge clk);
    #1;
    step();
    check_eq("rst_cmp_valid", cv_seen, 1'b0);
    check_eq("rst_cmp_id", id_seen, 2'd0);
    check_eq("rst_cnt", cnt_seen, 8'd0);
    rst = 1'b0;

    // Fixed priority: ports 0 and 2 request
    bus.req_i[0] = 8'hFF;
    bus.req_i[2] = 8'hFF;
    step();
    check_eq("fp_gnt", fp_gnt_seen, 3'b001);
    check_eq("fp_addr", fp_addr_seen, 64'h1000);
    bus.req_i = '0;
    step();
    check_eq("fp_cmp_valid", fp_cv_seen, 1'b1);
    check_eq("fp_cmp_id", fp_id_seen, 2'd0);

    // Round-robin rotation from reset
    rst_pulse();
    bus.req_i = '{default: 8'hFF};
    step(); check_eq("rr_0", gnt_seen, 3'b001);
    step(); check_eq("rr_1", gnt_seen, 3'b010);
    step(); check_eq("rr_2", gnt_seen, 3'b100);
    step(); check_eq("rr_3", gnt_seen, 3'b001);
    bus.req_i = '0;
    step();

    // Lock on port 2, then release
    rst_pulse();
    bus.req_i[2]  = 8'h0F;
    bus.lock_i[2] = 1'b1;
    step(); check_eq("lock_first", gnt_seen, 3'b100);
    bus.req_i = '{default: 8'hFF};
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("lock_hold", gnt_seen, 3'b100);
    end
    bus.lock_i = '0;
    step(); check_eq("lock_last", gnt_seen, 3'b100);
    step(); check_eq("lock_after", gnt_seen, 3'b001);
    // Locked port drops its request: lock released
    bus.req_i     = '0;
    bus.req_i[0]  = 8'h01;
    bus.lock_i[0] = 1'b1;
    step();
    bus.req_i     = '0;
    bus.req_i[1]  = 8'h01;
    bus.lock_i    = '0;
    step(); check_eq("lock_drop", gnt_seen, 3'b010);
    bus.req_i[0] = 8'h01;
    step(); check_eq("lock_gone", gnt_seen, 3'b001);
    bus.req_i = '0;
    step();

    // Single hit on way 5
    bus.tag_i[1] = 44'h3A;
    bus.tag_i[0] = 44'h11;
    bus.req_i[1] = 8'h20;
    step();
    bus.req_i = '0;
    set_way(5, 1'b1, 44'h3A);
    set_way(3, 1'b1, 44'h11);
    step();
    check_eq("hit_w5", hit_seen, 8'h20);
    check_eq("hit_mh", mh_seen, 1'b0);
    bus.req_i[1] = 8'h20;
    step();
    bus.req_i = '0;
    set_way(5, 1'b0, 44'h3A);
    step();
    check_eq("hit_inval", hit_seen, 8'h00);

    // Multi-hit on ways 2 and 6, then saturation
    bus.req_i[1] = 8'h44;
    step();
    set_way(2, 1'b1, 44'h3A);
    set_way(6, 1'b1, 44'h3A);
    bus.req_i = '0;
    step();
    check_eq("mh_pulse", mh_seen, 1'b1);
    check_eq("mh_cnt0", cnt_seen, 8'd0);
    step();
    check_eq("mh_clear", mh_seen, 1'b0);
    check_eq("mh_cnt1", cnt_seen, 8'd1);
    bus.req_i[1] = 8'h44;
    for (int c = 0; c < 300; c++) step();
    bus.req_i = '0;
    step();
    step();
    check_eq("mh_sat", cnt_seen, 8'd255);

    // Reset during the compare cycle of a hitting access
    bus.req_i[1] = 8'h44;
    step();
    bus.req_i = '0;
    rst = 1'b1;
    step();
    check_eq("rst_mid_valid", cv_seen, 1'b0);
    check_eq("rst_mid_hit", hit_seen, 8'h00);
    check_eq("rst_mid_cnt", cnt_seen, 8'd0);
    rst = 1'b0;
    step();

    // Clear in the grant cycle discards the compare
    bus.req_i[1] = 8'h44;
    clr = 1'b1;
    step();
    check_eq("clr_gnt", gnt_seen, 3'b010);
    clr = 1'b0;
    bus.req_i = '0;
    step();
    check_eq("clr_valid", cv_seen, 1'b0);
    check_eq("clr_hit", hit_seen, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
